demodulate: RTL and testbench
=============================

# demodulate

FM discriminator stage directly downstream of the complex channel FIR. Pops one filtered I/Q pair per sample, forms the conjugate product with the previous sample, and computes a fixed-point `qarctan` of that product using a sequential divider. It scales the angle by the demod gain and pushes one real sample to the audio-path FIFO. It is multi-cycle, with one sample in flight at a time.

## Interface
- `DATA_WIDTH`, 32: sample, coefficient and output width, signed.
- `BITS`, 10: quantization fraction bits. Comes from `GLOBALS`.
- `GAIN`, 758: quantized FM demod gain, `QUANTIZE(256000/(2π·55000))`.
- `QUAD1`, 804: quantized π/4.
- `QUAD3`, 2412: quantized 3π/4.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset is synchronous and active-high.
- `real_in` / `imag_in`  in  DATA_WIDTH  I and Q data from the FIR FIFOs (first-word-fall-through).
- `real_empty` / `imag_empty`  in  1  FIFO empty flags.
- `real_rd_en` / `imag_rd_en`  out  1  pop strobes; always asserted together.
- `demod_out`  out  DATA_WIDTH  demodulated sample.
- `demod_wr_en`  out  1  push strobe.
- `demod_full`  in  1  output FIFO full flag.

## Operation
`DEQ(x)` is a signed divide by 2^BITS that truncates toward zero (`GLOBALS::DEQUANTIZE_I`). `QUANT(x)` is `x << BITS`. Every product is computed at 2·DATA_WIDTH, dequantized, then truncated to DATA_WIDTH.

FSM states: READ, CMPLX, ATAN_SETUP, DIV_WAIT, ANGLE, WRITE.
- **READ:** if both FIFOs are non-empty, pulse both `rd_en`, latch `cur = (real_in, imag_in)`, go to CMPLX. Otherwise stay.
- **CMPLX:**
  - `r = DEQ(prev_r·cur_r) − DEQ(−prev_i·cur_i)`.
  - `i = DEQ(prev_r·cur_i) + DEQ(−prev_i·cur_r)`.
  - Set `prev <= cur`.
- **ATAN_SETUP:**
  - `abs_y = |i| + 1`.
  - If `r ≥ 0`: `num = QUANT(r − abs_y)`, `den = r + abs_y`, `base = QUAD1`.
  - Else: `num = QUANT(r + abs_y)`, `den = abs_y − r`, `base = QUAD3`.
  - Pulse `div` start. `den ≥ 1` by construction, so there is no divide-by-zero.
- **DIV_WAIT:** hold until `div` done. The quotient is truncated toward zero.
- **ANGLE:** `angle = base − DEQ(QUAD1·q)`. Negate `angle` if `i < 0`.
- **WRITE:**
  - Drive `demod_out = DEQ(GAIN·angle)`.
  - Assert `demod_wr_en` in the first cycle `demod_full` is low, then return to READ.
  - While full, hold the state and value, with `wr_en` low.

## Timing
- **Reset values:**
  - Outputs: all `rd_en`/`wr_en` = 0, `demod_out` = 0.
  - Internal: `prev` = (0,0), FSM = READ, divider idle.
- **Reset mid-operation:** aborts any sample in flight, including a busy divider. The popped sample is lost and nothing is written.
- **Divider:** radix-2, one quotient bit per cycle. `done` pulses exactly DATA_WIDTH cycles after the start cycle.
- **Latency:** with the rd_en cycle as cycle 0, the earliest `demod_wr_en` is cycle DATA_WIDTH+4 (cycle 36 at default width).
- **Throughput:** at most one sample per DATA_WIDTH+5 cycles.
- **Input handshake:** the FIFOs update on the edge ending the rd_en cycle. `rd_en` is never asserted outside READ or when either flag is empty.
- **One FIFO empty:** if only one FIFO is non-empty, neither is popped.
- **Output flags:** `demod_out` is don't-care when `wr_en` = 0. `wr_en` is never high while `demod_full` = 1.

## Structure
- `GLOBALS` package holds:
  - `BITS`, `QUANTIZE_I`, `DEQUANTIZE_I`;
  - `QUAD1`, `QUAD3`, `FM_DEMOD_GAIN` localparams;
  - the demod state enum typedef.
- One sub-module, `div`:
  - signed numerator by positive denominator, truncating toward zero;
  - ports `start`, `dividend`, `divisor`, `quotient`, `done`, `busy`;
  - synchronous active-high reset.
- The top level holds the FSM, the `prev` registers and the multipliers. Of those, at most two multiplies run per state.

## Test plan
- After reset, push (0,0) → r=i=0, q=−1024, angle=1608, `demod_out` = 1190 at cycle 36.
- Then push (1024,0) with prev (0,0) → `demod_out` = 1190. Push (1024,0) again → r=1024, i=0, q=1022, angle=2, `demod_out` = 1.
- Prev (1024,0), push (0,1024) → `demod_out` = 1190. Then reset. Prev (1024,0), push (0,−1024) → angle=−1608, `demod_out` = −1190 (truncation toward zero).
- Hold `demod_full` high for 50 cycles at WRITE → no `wr_en`, no `rd_en`, `demod_out` stable. Release → exactly one write, then READ.
- `real_empty`=0 with `imag_empty`=1 → no pops. Then assert `rst` during DIV_WAIT → no write, `prev` = 0, and the next sample (0,0) gives 1190.
- 100 random I/Q pairs against the C model → bit-exact outputs, with no drops or duplicates.

Source files
------------

// File: rtl/demodulate_pkg.sv
// Shared fixed-point helpers, angle/gain constants and the demod FSM state type.
package GLOBALS;

    localparam int BITS          = 10;
    localparam int QUAD1         = 804;   // pi/4 in Q.BITS
    localparam int QUAD3         = 2412;  // 3*pi/4 in Q.BITS
    localparam int FM_DEMOD_GAIN = 758;

    typedef enum logic [2:0] {
        READ,
        CMPLX,
        ATAN_SETUP,
        DIV_WAIT,
        ANGLE,
        WRITE
    } demod_state_t;

    function automatic logic signed [31:0] QUANTIZE_I(input logic signed [31:0] x);
        return x <<< BITS;
    endfunction

    // Divide by 2^BITS rounding toward zero: bias negatives before the arithmetic shift.
    function automatic logic signed [63:0] DEQUANTIZE_I(input logic signed [63:0] x);
        logic signed [63:0] bias;
        bias = x[63] ? ((64'sd1 <<< BITS) - 64'sd1) : 64'sd0;
        return (x + bias) >>> BITS;
    endfunction

endpackage

// File: rtl/demodulate_div.sv
// Radix-2 restoring divider: signed dividend by positive divisor, quotient truncated toward zero.
// The first quotient bit is resolved on the start edge, so done pulses W cycles after start.
module div #(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] dividend,
    input  logic signed [W-1:0] divisor,
    output logic signed [W-1:0] quotient,
    output logic                done,
    output logic                busy
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  r_rem, r_quo, r_den;
    logic [CW-1:0] r_cnt;
    logic          r_neg, r_busy, r_done;

    logic [W-1:0]  w_rem_in, w_quo_in, w_den_in, w_mag;
    logic [W:0]    w_shift, w_sub;
    logic          w_ge;

    assign w_mag    = dividend[W-1] ? W'(-dividend) : W'(dividend);
    assign w_rem_in = start ? '0 : r_rem;
    assign w_quo_in = start ? w_mag : r_quo;
    assign w_den_in = start ? W'(divisor) : r_den;
    assign w_shift  = {w_rem_in, w_quo_in[W-1]};
    assign w_sub    = w_shift - {1'b0, w_den_in};
    assign w_ge     = (w_shift >= {1'b0, w_den_in});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start || r_busy) begin
                r_rem <= w_ge ? w_sub[W-1:0] : w_shift[W-1:0];
                r_quo <= {w_quo_in[W-2:0], w_ge};
            end
            if (start) begin
                r_den  <= W'(divisor);
                r_neg  <= dividend[W-1];
                r_cnt  <= CW'(1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CW'(W-1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_neg ? -$signed(r_quo) : $signed(r_quo);
    assign done     = r_done;
    assign busy     = r_busy;

endmodule

// File: rtl/demodulate.sv
// FM discriminator: conjugate product with the previous I/Q sample, qarctan via a
// sequential divider, demod gain, one real sample out per input pair.
module demodulate
    import GLOBALS::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] real_in,
    input  logic signed [DATA_WIDTH-1:0] imag_in,
    input  logic                         real_empty,
    input  logic                         imag_empty,
    output logic                         real_rd_en,
    output logic                         imag_rd_en,
    output logic signed [DATA_WIDTH-1:0] demod_out,
    output logic                         demod_wr_en,
    input  logic                         demod_full
);
    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;

    typedef logic signed [W-1:0]  sw_t;
    typedef logic signed [PW-1:0] sp_t;

    function automatic sp_t sx(input sw_t v);
        return sp_t'(v);
    endfunction

    function automatic sw_t dq(input sp_t p);
        return sw_t'(DEQUANTIZE_I(p));
    endfunction

    demod_state_t r_state, w_next;

    sw_t r_prev_r, r_prev_i, r_cur_r, r_cur_i;
    sw_t r_pa, r_pb, r_re, r_im, r_base, r_angle;

    logic w_avail, w_pop, w_start, w_done, w_busy;
    sw_t  w_pa, w_pb, w_pc, w_pd;
    sw_t  w_abs_y, w_num, w_den, w_q, w_tmp, w_angle;

    assign w_avail = !real_empty && !imag_empty;
    assign w_pop   = (r_state == READ) && w_avail && !rst;

    // Half of the conjugate product is formed while popping so no state runs more than two multiplies.
    assign w_pa = dq(sx(r_prev_r) * sx(real_in));
    assign w_pb = dq(-(sx(r_prev_i) * sx(imag_in)));
    assign w_pc = dq(sx(r_prev_r) * sx(r_cur_i));
    assign w_pd = dq(-(sx(r_prev_i) * sx(r_cur_r)));

    assign w_abs_y = (r_im[W-1] ? -r_im : r_im) + sw_t'(1);
    assign w_num   = r_re[W-1] ? QUANTIZE_I(r_re + w_abs_y) : QUANTIZE_I(r_re - w_abs_y);
    assign w_den   = r_re[W-1] ? (w_abs_y - r_re) : (r_re + w_abs_y);

    assign w_tmp   = r_base - dq(sx(sw_t'(QUAD1)) * sx(w_q));
    assign w_angle = r_im[W-1] ? -w_tmp : w_tmp;

    div #(.W(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (w_num),
        .divisor  (w_den),
        .quotient (w_q),
        .done     (w_done),
        .busy     (w_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= READ;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            READ:       if (w_avail) w_next = CMPLX;
            CMPLX:      w_next = ATAN_SETUP;
            ATAN_SETUP: w_next = DIV_WAIT;
            DIV_WAIT:   if (w_done) w_next = ANGLE;
            ANGLE:      w_next = WRITE;
            WRITE:      if (!demod_full) w_next = READ;
            default:    w_next = READ;
        endcase
    end

    always_comb begin
        real_rd_en  = w_pop;
        imag_rd_en  = w_pop;
        w_start     = (r_state == ATAN_SETUP) && !w_busy;
        demod_wr_en = (r_state == WRITE) && !demod_full && !rst;
        demod_out   = rst ? '0 : dq(sx(sw_t'(FM_DEMOD_GAIN)) * sx(r_angle));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_r <= '0;
            r_prev_i <= '0;
            r_cur_r  <= '0;
            r_cur_i  <= '0;
            r_pa     <= '0;
            r_pb     <= '0;
            r_re     <= '0;
            r_im     <= '0;
            r_base   <= '0;
            r_angle  <= '0;
        end else begin
            case (r_state)
                READ: if (w_pop) begin
                    r_cur_r <= real_in;
                    r_cur_i <= imag_in;
                    r_pa    <= w_pa;
                    r_pb    <= w_pb;
                end
                CMPLX: begin
                    r_re     <= r_pa - r_pb;
                    r_im     <= w_pc + w_pd;
                    r_prev_r <= r_cur_r;
                    r_prev_i <= r_cur_i;
                end
                ATAN_SETUP: r_base <= r_re[W-1] ? sw_t'(QUAD3) : sw_t'(QUAD1);
                ANGLE:      r_angle <= w_angle;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_demodulate.sv
// Self-checking bench for demodulate: FWFT FIFO models on both sides, directed vectors,
// backpressure, reset abort and a randomized run against an arithmetic reference model.
module tb_demodulate;
    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] real_in = '0;
    logic signed [DW-1:0] imag_in = '0;
    logic                 real_empty = 1'b1;
    logic                 imag_empty = 1'b1;
    logic                 demod_full = 1'b0;
    logic                 real_rd_en, imag_rd_en, demod_wr_en;
    logic signed [DW-1:0] demod_out;

    int rq[$], iq[$], outq[$], wrcyc[$], rdcyc[$], expq[$];
    int cyc = 0, n_rd = 0, viol = 0;
    bit pop_r = 0, pop_i = 0;
    int n_checks = 0, n_fail = 0;
    int mpr = 0, mpi = 0;

    demodulate #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .real_in     (real_in),
        .imag_in     (imag_in),
        .real_empty  (real_empty),
        .imag_empty  (imag_empty),
        .real_rd_en  (real_rd_en),
        .imag_rd_en  (imag_rd_en),
        .demod_out   (demod_out),
        .demod_wr_en (demod_wr_en),
        .demod_full  (demod_full)
    );

    always #5 clk = ~clk;

    // Input FIFOs: pop what was strobed last cycle, then present the new head.
    always @(posedge clk) begin
        #1;
        if (pop_r && rq.size() > 0) void'(rq.pop_front());
        if (pop_i && iq.size() > 0) void'(iq.pop_front());
        real_in    = (rq.size() > 0) ? rq[0] : 0;
        imag_in    = (iq.size() > 0) ? iq[0] : 0;
        real_empty = (rq.size() == 0);
        imag_empty = (iq.size() == 0);
    end

    always @(negedge clk) begin
        cyc++;
        pop_r = real_rd_en;
        pop_i = imag_rd_en;
        if (real_rd_en) begin
            n_rd++;
            rdcyc.push_back(cyc);
        end
        if (demod_wr_en) begin
            outq.push_back(demod_out);
            wrcyc.push_back(cyc);
        end
        if (real_rd_en !== imag_rd_en) viol++;
        if (real_rd_en && (real_empty || imag_empty)) viol++;
        if (demod_wr_en && demod_full) viol++;
    end

    // Reference: conjugate product, qarctan, gain, all in plain integer arithmetic.
    function automatic int ref_demod(int pr, int pi, int cr, int ci);
        longint p;
        int r, i, absy, num, den, base, q, angle;
        r = int'((longint'(pr) * cr) / 1024) - int'((-(longint'(pi) * ci)) / 1024);
        i = int'((longint'(pr) * ci) / 1024) + int'((-(longint'(pi) * cr)) / 1024);
        absy = ((i < 0) ? -i : i) + 1;
        if (r >= 0) begin
            num = (r - absy) * 1024; den = r + absy; base = 804;
        end else begin
            num = (r + absy) * 1024; den = absy - r; base = 2412;
        end
        q = num / den;
        p = longint'(804) * q;
        angle = base - int'(p / 1024);
        if (i < 0) angle = -angle;
        return int'((longint'(758) * angle) / 1024);
    endfunction

    task automatic push(input int r, input int i);
        @(posedge clk); #2;
        rq.push_back(r);
        iq.push_back(i);
        expq.push_back(ref_demod(mpr, mpi, r, i));
        mpr = r;
        mpi = i;
    endtask

    task automatic wait_outs(input int n, input int bound);
        int k;
        k = 0;
        while (outq.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        mpr = 0;
        mpi = 0;
    endtask

    task automatic test_reset();
        int n0;
        n0 = outq.size();
        push(0, 0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (real_rd_en !== 1'b0 || imag_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_rd_en: got %b/%b expected 0/0", real_rd_en, imag_rd_en);
        end
        n_checks++;
        if (demod_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_wr_en: got %b expected 0", demod_wr_en);
        end
        @(posedge clk); #2; rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (demod_out !== 0) begin
            n_fail++; $display("FAIL reset_demod_out: got %0d expected 0", demod_out);
        end
        wait_outs(n0 + 1, 100);
        n_checks++;
        if (outq.size() != n0 + 1 || outq[n0] !== 1190) begin
            n_fail++; $display("FAIL first_zero_sample: got %0d outputs, value %0d expected 1190",
                               outq.size() - n0, (outq.size() > n0) ? outq[n0] : 0);
        end
        n_checks++;
        if (wrcyc.size() < 1 || rdcyc.size() < 1 || wrcyc[wrcyc.size()-1] - rdcyc[rdcyc.size()-1] != 36) begin
            n_fail++; $display("FAIL latency: got %0d expected 36",
                               (wrcyc.size() > 0 && rdcyc.size() > 0) ? wrcyc[wrcyc.size()-1] - rdcyc[rdcyc.size()-1] : -1);
        end
    endtask

    task automatic test_directed();
        int vr[6], vi[6], ve[6], n0;
        vr = '{1024, 1024, 0, 1024, 0, 0};
        vi = '{0, 0, 1024, 0, -1024, 0};
        ve = '{1190, 1, 1190, 1190, -1190, 0};
        for (int k = 0; k < 5; k++) begin
            if (k == 3) do_reset();
            n0 = outq.size();
            push(vr[k], vi[k]);
            wait_outs(n0 + 1, 100);
            n_checks++;
            if (outq.size() != n0 + 1 || outq[n0] !== ve[k]) begin
                n_fail++; $display("FAIL directed_%0d (%0d,%0d): got %0d expected %0d", k, vr[k], vi[k],
                                   (outq.size() > n0) ? outq[n0] : 32'hdead, ve[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = outq.size();
        push(300, -200);
        push(-1500, 700);
        push(-900, -2500);
        wait_outs(n0 + 3, 300);
        n_checks++;
        if (outq.size() != n0 + 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 3", outq.size() - n0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (outq[n0+k] !== expq[n0+k]) begin
                    n_fail++; $display("FAIL b2b_value_%0d: got %0d expected %0d", k, outq[n0+k], expq[n0+k]);
                end
            end
            n_checks++;
            if (wrcyc[n0+1] - wrcyc[n0] != 37 || wrcyc[n0+2] - wrcyc[n0+1] != 37) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d,%0d expected 37,37",
                                   wrcyc[n0+1] - wrcyc[n0], wrcyc[n0+2] - wrcyc[n0+1]);
            end
        end
    endtask

    task automatic test_full_hold();
        int n0, rd0, bad_wr, bad_hold;
        logic signed [DW-1:0] held;
        n0 = outq.size();
        rd0 = n_rd;
        @(posedge clk); #2; demod_full = 1'b1;
        push(2000, 1000);
        push(-700, 3000);
        repeat (45) @(negedge clk);
        held = demod_out;
        bad_wr = 0;
        bad_hold = 0;
        repeat (50) begin
            @(negedge clk);
            if (demod_wr_en !== 1'b0) bad_wr++;
            if (demod_out !== held) bad_hold++;
        end
        n_checks++;
        if (bad_wr != 0 || outq.size() != n0) begin
            n_fail++; $display("FAIL full_no_write: got %0d strobes expected 0", bad_wr);
        end
        n_checks++;
        if (bad_hold != 0) begin
            n_fail++; $display("FAIL full_out_stable: got %0d changed cycles expected 0", bad_hold);
        end
        n_checks++;
        if (n_rd - rd0 != 1) begin
            n_fail++; $display("FAIL full_no_pop: got %0d pops expected 1", n_rd - rd0);
        end
        @(posedge clk); #2; demod_full = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (outq.size() != n0 + 1 || outq[n0] !== expq[n0]) begin
            n_fail++; $display("FAIL full_release: got %0d writes value %0d expected 1 write value %0d",
                               outq.size() - n0, (outq.size() > n0) ? outq[n0] : 0, expq[n0]);
        end
        wait_outs(n0 + 2, 100);
        n_checks++;
        if (outq.size() != n0 + 2 || outq[n0+1] !== expq[n0+1]) begin
            n_fail++; $display("FAIL full_next_sample: got %0d expected %0d",
                               (outq.size() > n0 + 1) ? outq[n0+1] : 0, expq[n0+1]);
        end
    endtask

    task automatic test_one_empty_and_abort();
        int rd0, n0, k;
        rd0 = n_rd;
        @(posedge clk); #2; rq.push_back(1024);
        repeat (20) @(negedge clk);
        n_checks++;
        if (n_rd != rd0) begin
            n_fail++; $display("FAIL one_empty_pop: got %0d pops expected 0", n_rd - rd0);
        end
        // Completing the pair pops (1024,0); reset lands in DIV_WAIT and must discard it.
        @(posedge clk); #2; iq.push_back(0);
        k = 0;
        while (n_rd == rd0 && k < 20) begin @(negedge clk); k++; end
        n_checks++;
        if (n_rd != rd0 + 1) begin
            n_fail++; $display("FAIL pair_pop: got %0d pops expected 1", n_rd - rd0);
        end
        n0 = outq.size();
        repeat (10) @(negedge clk);
        do_reset();
        repeat (60) @(negedge clk);
        n_checks++;
        if (outq.size() != n0) begin
            n_fail++; $display("FAIL abort_no_write: got %0d writes expected 0", outq.size() - n0);
        end
        push(1024, 0);
        wait_outs(n0 + 1, 100);
        n_checks++;
        if (outq.size() != n0 + 1 || outq[n0] !== 1190) begin
            n_fail++; $display("FAIL abort_prev_cleared: got %0d expected 1190",
                               (outq.size() > n0) ? outq[n0] : 0);
        end
        push(0, 0);
        wait_outs(n0 + 2, 100);
        n_checks++;
        if (outq.size() != n0 + 2 || outq[n0+1] !== 1190) begin
            n_fail++; $display("FAIL abort_zero_sample: got %0d expected 1190",
                               (outq.size() > n0 + 1) ? outq[n0+1] : 0);
        end
    endtask

    task automatic test_random();
        int n0, e0;
        bit fin;
        n0 = outq.size();
        e0 = expq.size();
        fin = 0;
        fork
            begin
                while (!fin) begin
                    @(posedge clk); #1;
                    demod_full = ($urandom_range(3) == 0);
                end
                demod_full = 1'b0;
            end
            begin
                for (int k = 0; k < 100; k++)
                    push(int'($urandom_range(8191)) - 4096, int'($urandom_range(8191)) - 4096);
                wait_outs(n0 + 100, 12000);
                repeat (50) @(negedge clk);
                fin = 1;
            end
        join
        n_checks++;
        if (outq.size() - n0 != 100) begin
            n_fail++; $display("FAIL random_count: got %0d expected 100", outq.size() - n0);
        end
        for (int k = 0; k < 100 && n0 + k < outq.size(); k++) begin
            n_checks++;
            if (outq[n0+k] !== expq[e0+k]) begin
                n_fail++; $display("FAIL random_%0d: got %0d expected %0d", k, outq[n0+k], expq[e0+k]);
            end
        end
        n_checks++;
        if (viol != 0) begin
            n_fail++; $display("FAIL handshake_rules: got %0d violations expected 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_full_hold();
        test_one_empty_and_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
